// File: rtl/synth_pkg.sv
// Shared definitions for the synth datapath: waveform mode type and block defaults.
// Latency: n/a (types, constants and an elaboration-time helper only).
// Backpressure: n/a.
package synth_pkg;

    // Encodings are owned by waveform_fsm; this block only stores and forwards them.
    typedef logic [1:0] mode_t;

    localparam int NUM_KEYS_DEF   = 8;
    localparam int NUM_VOICES_DEF = 4;

    // Index width that never collapses to zero bits, even for a single-entry vector.
    function automatic int clog2_min1(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/voice_allocator_lsb_pick.sv
// Lowest-set-bit finder: reports whether any bit of vec is set and the index of the lowest one.
// Latency: purely combinational.
// Backpressure: none.
module lsb_pick
    import synth_pkg::*;
#(
    parameter int W  = 8,
    parameter int IW = clog2_min1(W)
) (
    input  logic [W-1:0]  vec,
    output logic          found,
    output logic [IW-1:0] idx
);

    // Scan from the top so the last hit, and therefore the result, is the lowest set bit.
    always_comb begin
        found = 1'b0;
        idx   = '0;
        for (int i = W - 1; i >= 0; i--) begin
            if (vec[i]) begin
                found = 1'b1;
                idx   = IW'(i);
            end
        end
    end

endmodule

// File: rtl/voice_allocator.sv
// Polyphony scheduler: maps pressed keys onto oscillator voices, stealing the oldest voice when all are busy.
// Latency: one event per clk (release beats press), registered outputs change 1 cycle after keys.
// Backpressure: none; pending key changes stay visible in keys vs assigned/dropped and drain one per cycle.
module voice_allocator
    import synth_pkg::*;
#(
    parameter int  NUM_KEYS   = NUM_KEYS_DEF,
    parameter int  NUM_VOICES = NUM_VOICES_DEF,
    parameter int  AGE_W      = 8,
    localparam int KEY_W      = $clog2(NUM_KEYS),
    localparam int VOICE_W    = clog2_min1(NUM_VOICES)
) (
    input  logic                          clk,
    input  logic                          n_rst,
    input  logic [NUM_KEYS-1:0]           keys,
    input  logic [1:0]                    mode,
    output logic [NUM_VOICES-1:0]         voice_active,
    output logic [NUM_VOICES*KEY_W-1:0]   voice_key,
    output logic [NUM_VOICES*2-1:0]       voice_mode,
    output logic [NUM_VOICES-1:0]         voice_start,
    output logic                          steal
);

    logic [NUM_KEYS-1:0]                  assigned_q, assigned_d;
    logic [NUM_KEYS-1:0]                  dropped_q, dropped_d;
    logic [NUM_VOICES-1:0]                active_q, active_d;
    logic [NUM_VOICES-1:0]                start_q, start_d;
    logic [NUM_VOICES-1:0][KEY_W-1:0]     key_q, key_d;
    mode_t [NUM_VOICES-1:0]               mode_q, mode_d;
    logic [NUM_VOICES-1:0][AGE_W-1:0]     age_q, age_d;
    logic                                 steal_q, steal_d;

    logic                                 rel_found, press_found, free_found;
    logic [KEY_W-1:0]                     rel_key, press_key;
    logic [VOICE_W-1:0]                   free_v, old_v, rel_v, tgt_v;

    lsb_pick #(.W(NUM_KEYS), .IW(KEY_W)) u_rel_pick (
        .vec   (assigned_q & ~keys),
        .found (rel_found),
        .idx   (rel_key)
    );

    lsb_pick #(.W(NUM_KEYS), .IW(KEY_W)) u_press_pick (
        .vec   (keys & ~assigned_q & ~dropped_q),
        .found (press_found),
        .idx   (press_key)
    );

    lsb_pick #(.W(NUM_VOICES), .IW(VOICE_W)) u_free_pick (
        .vec   (~active_q),
        .found (free_found),
        .idx   (free_v)
    );

    // Oldest voice: strict greater-than keeps the lowest index on age ties.
    always_comb begin
        old_v = '0;
        for (int v = 1; v < NUM_VOICES; v++) begin
            if (age_q[v] > age_q[old_v]) old_v = VOICE_W'(v);
        end
    end

    // Voice owned by the key being released; exactly one active voice matches an assigned key.
    always_comb begin
        rel_v = '0;
        for (int v = 0; v < NUM_VOICES; v++) begin
            if (active_q[v] && (key_q[v] == rel_key)) rel_v = VOICE_W'(v);
        end
    end

    // Event servicing: one release, else one press (free voice first, otherwise steal the oldest).
    always_comb begin
        assigned_d = assigned_q;
        dropped_d  = dropped_q & keys;
        active_d   = active_q;
        key_d      = key_q;
        mode_d     = mode_q;
        age_d      = age_q;
        start_d    = '0;
        steal_d    = 1'b0;
        tgt_v      = free_found ? free_v : old_v;

        if (rel_found) begin
            active_d[rel_v]     = 1'b0;
            assigned_d[rel_key] = 1'b0;
        end else if (press_found) begin
            if (!free_found) begin
                // The victim key is still held (no release was pending), so it stays dropped until let go.
                steal_d                     = 1'b1;
                assigned_d[key_q[tgt_v]]    = 1'b0;
                dropped_d[key_q[tgt_v]]     = 1'b1;
            end
            for (int v = 0; v < NUM_VOICES; v++) begin
                if (active_q[v] && (age_q[v] != '1)) age_d[v] = age_q[v] + 1'b1;
            end
            age_d[tgt_v]          = '0;
            key_d[tgt_v]          = press_key;
            mode_d[tgt_v]         = mode;
            active_d[tgt_v]       = 1'b1;
            start_d[tgt_v]        = 1'b1;
            assigned_d[press_key] = 1'b1;
        end
    end

    // State and output registers.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            assigned_q <= '0;
            dropped_q  <= '0;
            active_q   <= '0;
            start_q    <= '0;
            key_q      <= '0;
            mode_q     <= '0;
            age_q      <= '0;
            steal_q    <= 1'b0;
        end else begin
            assigned_q <= assigned_d;
            dropped_q  <= dropped_d;
            active_q   <= active_d;
            start_q    <= start_d;
            key_q      <= key_d;
            mode_q     <= mode_d;
            age_q      <= age_d;
            steal_q    <= steal_d;
        end
    end

    assign voice_active = active_q;
    assign voice_key    = key_q;
    assign voice_mode   = mode_q;
    assign voice_start  = start_q;
    assign steal        = steal_q;

endmodule

// File: tb/tb_voice_allocator.sv
module tb_voice_allocator;

    localparam int NK = 8;
    localparam int NV = 4;

    logic        clk = 1'b0;
    logic        n_rst;
    logic [7:0]  keys;
    logic [1:0]  mode;
    logic [3:0]  voice_active;
    logic [11:0] voice_key;
    logic [7:0]  voice_mode;
    logic [3:0]  voice_start;
    logic        steal;

    voice_allocator #(.NUM_KEYS(NK), .NUM_VOICES(NV), .AGE_W(8)) dut (
        .clk          (clk),
        .n_rst        (n_rst),
        .keys         (keys),
        .mode         (mode),
        .voice_active (voice_active),
        .voice_key    (voice_key),
        .voice_mode   (voice_mode),
        .voice_start  (voice_start),
        .steal        (steal)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    logic [28:0] dut_vec;
    assign dut_vec = {voice_active, voice_key, voice_mode, voice_start, steal};

    // Reference model: who owns what, in plain integers.
    bit m_assigned[NK];
    bit m_dropped[NK];
    bit m_act[NV];
    bit m_start[NV];
    int m_key[NV];
    int m_mode[NV];
    int m_age[NV];
    bit m_steal;

    function automatic void model_reset();
        for (int i = 0; i < NK; i++) begin
            m_assigned[i] = 0;
            m_dropped[i]  = 0;
        end
        for (int v = 0; v < NV; v++) begin
            m_act[v] = 0; m_start[v] = 0; m_key[v] = 0; m_mode[v] = 0; m_age[v] = 0;
        end
        m_steal = 0;
    endfunction

    function automatic void model_step(input logic [7:0] k, input logic [1:0] md);
        int rk = -1;
        int pk = -1;
        int v  = -1;
        m_steal = 0;
        for (int u = 0; u < NV; u++) m_start[u] = 0;
        for (int i = NK - 1; i >= 0; i--) if (m_assigned[i] && !k[i]) rk = i;
        if (rk >= 0) begin
            for (int u = 0; u < NV; u++) if (m_act[u] && m_key[u] == rk) m_act[u] = 0;
            m_assigned[rk] = 0;
        end else begin
            for (int i = NK - 1; i >= 0; i--) if (k[i] && !m_assigned[i] && !m_dropped[i]) pk = i;
            if (pk >= 0) begin
                for (int u = NV - 1; u >= 0; u--) if (!m_act[u]) v = u;
                if (v < 0) begin
                    v = 0;
                    for (int u = 1; u < NV; u++) if (m_age[u] > m_age[v]) v = u;
                    m_steal = 1;
                    m_assigned[m_key[v]] = 0;
                    m_dropped[m_key[v]]  = 1;
                end
                for (int u = 0; u < NV; u++) if (u != v && m_act[u]) m_age[u] = (m_age[u] >= 255) ? 255 : m_age[u] + 1;
                m_age[v]       = 0;
                m_key[v]       = pk;
                m_mode[v]      = md;
                m_act[v]       = 1;
                m_start[v]     = 1;
                m_assigned[pk] = 1;
            end
        end
        for (int i = 0; i < NK; i++) if (!k[i]) m_dropped[i] = 0;
    endfunction

    function automatic logic [28:0] model_vec();
        logic [3:0]  a;
        logic [3:0]  s;
        logic [11:0] kk;
        logic [7:0]  mm;
        for (int u = 0; u < NV; u++) begin
            a[u]         = m_act[u];
            s[u]         = m_start[u];
            kk[u*3 +: 3] = 3'(m_key[u]);
            mm[u*2 +: 2] = 2'(m_mode[u]);
        end
        return {a, kk, mm, s, m_steal};
    endfunction

    // Apply inputs away from the edge, clock once, advance model, land 1 time unit after the edge.
    task automatic step(input logic [7:0] k, input logic [1:0] md);
        keys = k;
        mode = md;
        @(posedge clk);
        model_step(k, md);
        #1;
    endtask

    task automatic pulse_reset();
        #2 n_rst = 1'b0;
        model_reset();
        #1;
        @(negedge clk);
        n_rst = 1'b1;
    endtask

    task automatic test_reset();
        n_rst = 1'b0;
        keys  = '0;
        mode  = '0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (dut_vec !== 29'd0) begin
            failures++;
            $display("FAIL reset_state got=%h want=0", dut_vec);
        end
        @(negedge clk);
        n_rst = 1'b1;
        for (int i = 0; i < 2; i++) begin
            step(8'h00, 2'd0);
            checks++;
            if (dut_vec !== 29'd0) begin
                failures++;
                $display("FAIL reset_idle%0d got=%h want=0", i, dut_vec);
            end
        end
    endtask

    task automatic test_press_and_fill();
        step(8'b0000_1000, 2'd2);
        checks++;
        if (voice_active !== 4'b0001 || voice_key[2:0] !== 3'd3 || voice_mode[1:0] !== 2'd2 ||
            voice_start !== 4'b0001 || steal !== 1'b0) begin
            failures++;
            $display("FAIL first_press act=%b key0=%0d mode0=%0d start=%b steal=%b want 0001 3 2 0001 0",
                     voice_active, voice_key[2:0], voice_mode[1:0], voice_start, steal);
        end
        step(8'b0000_1000, 2'd1);
        checks++;
        if (voice_start !== 4'b0000 || voice_mode[1:0] !== 2'd2) begin
            failures++;
            $display("FAIL start_pulse_len start=%b mode0=%0d want 0000 2", voice_start, voice_mode[1:0]);
        end
        for (int i = 0; i < 3; i++) begin
            step(8'b0000_1111, 2'd1);
            checks++;
            if (voice_key[(i+1)*3 +: 3] !== 3'(i) || voice_start !== 4'(1 << (i + 1)) ||
                voice_mode[(i+1)*2 +: 2] !== 2'd1 || steal !== 1'b0) begin
                failures++;
                $display("FAIL backlog_key%0d key=%0d start=%b steal=%b want %0d %b 0",
                         i, voice_key[(i+1)*3 +: 3], voice_start, steal, i, 4'(1 << (i + 1)));
            end
        end
        checks++;
        if (voice_active !== 4'b1111) begin
            failures++;
            $display("FAIL all_busy act=%b want 1111", voice_active);
        end
    endtask

    task automatic test_steal_and_drop();
        step(8'b0010_1111, 2'd3);
        checks++;
        if (steal !== 1'b1 || voice_key[2:0] !== 3'd5 || voice_start !== 4'b0001 ||
            voice_mode[1:0] !== 2'd3 || voice_active !== 4'b1111) begin
            failures++;
            $display("FAIL steal_oldest steal=%b key0=%0d start=%b mode0=%0d act=%b want 1 5 0001 3 1111",
                     steal, voice_key[2:0], voice_start, voice_mode[1:0], voice_active);
        end
        step(8'b0010_0111, 2'd0);
        checks++;
        if (steal !== 1'b0 || voice_start !== 4'b0000 || voice_active !== 4'b1111 || voice_key !== 12'b010_001_000_101) begin
            failures++;
            $display("FAIL dropped_release steal=%b start=%b act=%b keys=%h want 0 0000 1111 %h",
                     steal, voice_start, voice_active, voice_key, 12'b010_001_000_101);
        end
    endtask

    task automatic test_release_first();
        step(8'b0100_0111, 2'd2);
        checks++;
        if (voice_active !== 4'b1110 || voice_start !== 4'b0000 || voice_key[2:0] !== 3'd5) begin
            failures++;
            $display("FAIL release_priority act=%b start=%b key0=%0d want 1110 0000 5", voice_active, voice_start, voice_key[2:0]);
        end
        step(8'b0100_0111, 2'd2);
        checks++;
        if (voice_active !== 4'b1111 || voice_start !== 4'b0001 || voice_key[2:0] !== 3'd6 || steal !== 1'b0) begin
            failures++;
            $display("FAIL press_after_release act=%b start=%b key0=%0d steal=%b want 1111 0001 6 0",
                     voice_active, voice_start, voice_key[2:0], steal);
        end
    endtask

    task automatic test_mid_reset();
        step(8'b0000_0110, 2'd1);
        #2 n_rst = 1'b0;
        model_reset();
        #1;
        checks++;
        if (dut_vec !== 29'd0) begin
            failures++;
            $display("FAIL async_reset got=%h want=0", dut_vec);
        end
        @(negedge clk);
        n_rst = 1'b1;
        step(8'b0000_0110, 2'd1);
        checks++;
        if (voice_active !== 4'b0001 || voice_key[2:0] !== 3'd1 || voice_start !== 4'b0001) begin
            failures++;
            $display("FAIL realloc_key1 act=%b key0=%0d start=%b want 0001 1 0001", voice_active, voice_key[2:0], voice_start);
        end
        step(8'b0000_0110, 2'd1);
        checks++;
        if (voice_active !== 4'b0011 || voice_key[5:3] !== 3'd2 || voice_start !== 4'b0010) begin
            failures++;
            $display("FAIL realloc_key2 act=%b key1=%0d start=%b want 0011 2 0010", voice_active, voice_key[5:3], voice_start);
        end
    endtask

    task automatic test_age_saturation();
        step(8'h00, 2'd0);
        step(8'h00, 2'd0);
        step(8'b0000_0001, 2'd0);
        for (int i = 0; i < 254; i++) begin
            step(8'b0000_0011, 2'd0);
            step(8'b0000_0001, 2'd0);
        end
        step(8'b0000_0101, 2'd0);
        step(8'b0000_0111, 2'd0);
        step(8'b0000_1111, 2'd0);
        step(8'b0001_1111, 2'd0);
        checks++;
        if (steal !== 1'b1 || voice_key[2:0] !== 3'd4 || voice_start !== 4'b0001) begin
            failures++;
            $display("FAIL age_saturate steal=%b key0=%0d start=%b want 1 4 0001", steal, voice_key[2:0], voice_start);
        end
        checks++;
        if (dut_vec !== model_vec()) begin
            failures++;
            $display("FAIL age_model got=%h want=%h", dut_vec, model_vec());
        end
    endtask

    task automatic test_random();
        logic [7:0] k;
        k = keys;
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(0, 399) == 0) begin
                pulse_reset();
                checks++;
                if (dut_vec !== 29'd0) begin
                    failures++;
                    $display("FAIL rand_reset cycle=%0d got=%h want=0", c, dut_vec);
                end
            end
            if ($urandom_range(0, 19) == 0) k = 8'($urandom);
            else if ($urandom_range(0, 2) == 0) k[$urandom_range(0, 7)] ^= 1'b1;
            step(k, 2'($urandom_range(0, 3)));
            checks++;
            if (dut_vec !== model_vec()) begin
                failures++;
                $display("FAIL rand_cycle%0d keys=%b got=%h want=%h", c, k, dut_vec, model_vec());
            end
        end
    endtask

    initial begin
        test_reset();
        test_press_and_fill();
        test_steal_and_drop();
        test_release_first();
        test_mid_reset();
        pulse_reset();
        test_age_saturation();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
